// File: rtl/seg_scan_rx.sv
// Receiver for the six-digit multiplexed 7-segment scan bus: it debounces each dwell,
// decodes the segment pattern back to a digit code and assembles six-digit frames.

module seg_scan_lane (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [3:0] code,
  input  logic       dp,
  input  logic       clr,
  output logic [3:0] digit,
  output logic       dp_q,
  output logic       code_err
);
  always_ff @(posedge clk) begin
    if (rst) begin
      digit    <= 4'hE;
      dp_q     <= 1'b0;
      code_err <= 1'b0;
    end else begin
      if (we) begin
        digit <= code;
        dp_q  <= dp;
      end
      // A fresh decode error beats a simultaneous clear.
      if (we && code == 4'hF) code_err <= 1'b1;
      else if (clr)           code_err <= 1'b0;
    end
  end
endmodule

module seg_scan_rx #(
  parameter int NUM_DIG = 6,
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 50000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_DIG-1:0]   i_seg_enb,
  input  logic [6:0]           i_seg,
  input  logic                 i_seg_dp,
  input  logic                 i_clr,
  output logic [4*NUM_DIG-1:0] o_digits,
  output logic [NUM_DIG-1:0]   o_dp,
  output logic                 o_frame_valid,
  output logic                 o_err,
  output logic [NUM_DIG-1:0]   o_code_err,
  output logic                 o_stale
);
  localparam int CW = $clog2(SETTLE + 1);

  typedef struct packed {
    logic [NUM_DIG-1:0] enb;
    logic [6:0]         seg;
    logic               dp;
  } smp_t;

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_HOLD} st_t;

  function automatic logic [3:0] dec(input logic [6:0] s);
    case (s)
      7'h7E:   dec = 4'h0;
      7'h30:   dec = 4'h1;
      7'h6D:   dec = 4'h2;
      7'h79:   dec = 4'h3;
      7'h33:   dec = 4'h4;
      7'h5B:   dec = 4'h5;
      7'h5F:   dec = 4'h6;
      7'h70:   dec = 4'h7;
      7'h7F:   dec = 4'h8;
      7'h73:   dec = 4'h9;
      7'h00:   dec = 4'hE;
      default: dec = 4'hF;
    endcase
  endfunction

  function automatic logic one_low(input logic [NUM_DIG-1:0] enb);
    logic [NUM_DIG-1:0] lo;
    lo      = ~enb;
    one_low = (lo != '0) && ((lo & (lo - 1'b1)) == '0);
  endfunction

  smp_t               in_s, smp_q;
  st_t                st_q;
  logic [CW-1:0]      cnt_q;
  logic [NUM_DIG-1:0] mask_q, lo, mask_nxt, we;
  logic [31:0]        stl_q;
  logic               same, settle_hit, cap, multi_lo, err_set;
  logic [NUM_DIG-1:0][3:0] digits;
  logic [3:0]         code;

  assign in_s       = {i_seg_enb, i_seg, i_seg_dp};
  assign same       = (in_s == smp_q);
  assign lo         = ~smp_q.enb;
  assign multi_lo   = (lo & (lo - 1'b1)) != '0;
  // Compare against the incoming sample so the capture lands SETTLE-1 edges after the
  // pattern is first registered.
  assign settle_hit = same && (cnt_q == CW'(SETTLE - 2));
  assign cap        = settle_hit && (st_q == ST_SETTLE);
  assign err_set    = settle_hit && multi_lo;
  assign we         = cap ? lo : '0;
  assign mask_nxt   = mask_q | lo;
  assign code       = dec(smp_q.seg);

  always_ff @(posedge clk) begin
    if (rst) begin
      smp_q         <= '{enb: '1, seg: '0, dp: 1'b0};
      cnt_q         <= '0;
      st_q          <= ST_IDLE;
      mask_q        <= '0;
      o_frame_valid <= 1'b0;
      o_err         <= 1'b0;
      stl_q         <= '0;
    end else begin
      smp_q         <= in_s;
      o_frame_valid <= 1'b0;

      if (!same)                  cnt_q <= '0;
      else if (cnt_q < CW'(SETTLE)) cnt_q <= cnt_q + 1'b1;

      if (!same) st_q <= one_low(in_s.enb) ? ST_SETTLE : ST_IDLE;
      else if (cap) st_q <= ST_HOLD;

      if (cap) begin
        if (mask_nxt == '1) begin
          mask_q        <= '0;
          o_frame_valid <= 1'b1;
        end else begin
          mask_q <= mask_nxt;
        end
      end

      if (err_set)    o_err <= 1'b1;
      else if (i_clr) o_err <= 1'b0;

      if (cap)                       stl_q <= '0;
      else if (stl_q < 32'(TIMEOUT)) stl_q <= stl_q + 32'd1;
    end
  end

  assign o_stale  = (stl_q >= 32'(TIMEOUT));
  assign o_digits = digits;

  for (genvar k = 0; k < NUM_DIG; k++) begin : g_lane
    seg_scan_lane u_lane (
      .clk      (clk),
      .rst      (rst),
      .we       (we[k]),
      .code     (code),
      .dp       (smp_q.dp),
      .clr      (i_clr),
      .digit    (digits[k]),
      .dp_q     (o_dp[k]),
      .code_err (o_code_err[k])
    );
  end
endmodule
